// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-select 7-segment display.
// Patterns are snapshotted once per frame; every output is registered.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 10000,
  parameter int GAP_CYC     = 100,
  parameter bit COM_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    EN,
  input  logic [7*NUM_DIGITS-1:0] SEG_PAT,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   DIG_EN,
  output logic [7:0]              SEG_COM,
  output logic [7:0]              SEG_DATA,
  output logic                    FRAME_TICK
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
                                                : ((GAP_CYC > 2) ? GAP_CYC : 2);
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0]    COM_OFF   = COM_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    GAP
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [7*NUM_DIGITS-1:0] snap_pat;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_dig_en;

  // Outputs are computed from the current state, so they trail the state by one edge.
  always_ff @(posedge CLK) begin
    if (Reset || !EN) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      SEG_COM    <= COM_OFF;
      SEG_DATA   <= SEG_OFF;
      FRAME_TICK <= 1'b0;
      if (Reset) begin
        snap_pat    <= '0;
        snap_dp     <= '0;
        snap_dig_en <= '0;
      end
    end else begin
      SEG_COM    <= COM_OFF;
      SEG_DATA   <= SEG_OFF;
      FRAME_TICK <= 1'b0;
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          FRAME_TICK  <= 1'b1;
          snap_pat    <= SEG_PAT;
          snap_dp     <= DP;
          snap_dig_en <= DIG_EN;
          idx         <= '0;
          cnt         <= '0;
          state       <= SHOW;
        end
        SHOW: begin
          if (snap_dig_en[idx]) SEG_COM <= COM_OFF ^ (8'd1 << idx);
          SEG_DATA <= SEG_OFF ^ {snap_pat[7*int'(idx) +: 7], snap_dp[idx]};
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (GAP_CYC > 0) state <= GAP;
            else if (idx == IDX_LAST) state <= LOAD;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= LOAD;
            end else begin
              idx   <= idx + 1'b1;
              state <= SHOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: one instance with a 2-cycle gap and one with no gap,
// both compared every cycle against a frame-position model.
module tb_seg_scan_driver;

  localparam int ND = 3;
  localparam int SD = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [7*ND-1:0] seg_pat;
  logic [ND-1:0] dp;
  logic [ND-1:0] dig_en;
  logic [7:0]    com, data, com0, data0;
  logic          tick, tick0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp0_q[$];

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .GAP_CYC(2), .COM_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
  ) dut (
    .CLK(clk), .Reset(rst), .EN(en), .SEG_PAT(seg_pat), .DP(dp), .DIG_EN(dig_en),
    .SEG_COM(com), .SEG_DATA(data), .FRAME_TICK(tick)
  );

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .GAP_CYC(0), .COM_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
  ) dut0 (
    .CLK(clk), .Reset(rst), .EN(en), .SEG_PAT(seg_pat), .DP(dp), .DIG_EN(dig_en),
    .SEG_COM(com0), .SEG_DATA(data0), .FRAME_TICK(tick0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // reference model: outputs after the k-th enabled edge, from the position in the frame
  int         kk[2];
  int         last_tick[2];
  logic [6:0] m_pat[2][ND];
  logic       m_dp[2][ND];
  logic       m_en[2][ND];

  initial begin
    kk[0] = 0; kk[1] = 0;
    last_tick[0] = -1; last_tick[1] = -1;
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int g, slot, per, p, q, d, r;
      logic [7:0] e_com, e_data;
      logic       e_tick;
      g      = (m == 0) ? 2 : 0;
      slot   = SD + g;
      per    = ND * slot + 1;
      e_com  = 8'hFF;
      e_data = 8'h00;
      e_tick = 1'b0;
      if (rst || !en) begin
        kk[m] = 0;
        last_tick[m] = -1;
      end else begin
        kk[m]++;
        if (kk[m] >= 2) begin
          p = (kk[m] - 2) % per;
          if (p == 0) begin
            e_tick = 1'b1;
            for (int i = 0; i < ND; i++) begin
              m_pat[m][i] = seg_pat[7*i +: 7];
              m_dp[m][i]  = dp[i];
              m_en[m][i]  = dig_en[i];
            end
          end else begin
            q = p - 1;
            d = q / slot;
            r = q % slot;
            if (r < SD) begin
              if (m_en[m][d]) e_com = ~(8'd1 << d);
              e_data = {m_pat[m][d], m_dp[m][d]};
            end
          end
        end
      end
      if (m == 0) exp_q.push_back({e_com, e_data, e_tick});
      else exp0_q.push_back({e_com, e_data, e_tick});
    end
  end

  // scoreboard: one expected entry per edge, compared away from the edge
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("com", com, e[16:9]);
      check_eq("data", data, e[8:1]);
      check_eq("tick", tick, e[0]);
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      check_eq("com0", com0, e[16:9]);
      check_eq("data0", data0, e[8:1]);
      check_eq("tick0", tick0, e[0]);
    end
    if (tick === 1'b1) begin
      if (last_tick[0] >= 0) check_eq("period", cyc - last_tick[0], 19);
      last_tick[0] = cyc;
    end
    if (tick0 === 1'b1) begin
      if (last_tick[1] >= 0) check_eq("period0", cyc - last_tick[1], 13);
      last_tick[1] = cyc;
    end
  end

  // driver tasks
  task automatic rand_inputs(input bit rand_en_mask);
    seg_pat = 21'($urandom);
    dp      = 3'($urandom_range(0, 7));
    if (rand_en_mask) dig_en = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_com(input logic [7:0] want, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (com === want) hit = 1'b1;
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1; en = 1'b1; seg_pat = '0; dp = '0; dig_en = '1;
    repeat (3) @(negedge clk);
    check_eq("rst_com", com, 8'hFF);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_tick", tick, 1'b0);

    // digit 1 shows "1" with its decimal point
    seg_pat = 21'($urandom);
    seg_pat[13:7] = 7'b0110000;
    dp = 3'b010; dig_en = 3'b111;
    rst = 1'b0;
    wait_com(8'hFD, 40, hit);
    check_eq("t3_wait", hit, 1'b1);
    if (hit) check_eq("t3_data", data, 8'b01100001);
    repeat (95) @(negedge clk);

    // mid-frame input changes must only show after the next capture
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) rand_inputs(1'b0);
    end

    dig_en = 3'b011;
    repeat (80) @(negedge clk);
    dig_en = 3'b111;

    repeat (8) begin
      repeat ($urandom_range(3, 40)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      en = 1'b1;
    end

    repeat (8) begin
      repeat ($urandom_range(3, 40)) @(negedge clk);
      rst = 1'b1;
      if ($urandom_range(0, 1) == 1) en = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
    end

    repeat (300) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) rand_inputs(1'b1);
      if ($urandom_range(0, 60) == 0) en = 1'b0;
      else en = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
